// File: rtl/pix_buf_arb.sv
// -----------------------------------------------------------------------------
// pix_buf_arb
//   Round-robin arbiter giving NUM_REQ pixel-processing stages (intensity
//   gradient, edge thinning, edge tracking, rectify/clip) shared access to a
//   single-port pixel buffer. The grant is registered; the memory port is
//   muxed combinationally from the granted requester. A granted requester may
//   hold the grant with `lock` for at most MAX_LOCK consecutive access cycles
//   while someone else is waiting.
//
//   Optional feature: define PIX_BUF_ARB_GNT_CNT_EN to build a saturating
//   16-bit count of access cycles on gnt_cnt; otherwise gnt_cnt is tied to 0.
//
// Ports
//   clk        sole clock, posedge
//   rst        synchronous active-high reset
//   req        per-requester access request
//   lock       per-requester burst hold (only used for the current owner)
//   req_addr   flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_we     per-requester write enable
//   req_wdata  flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        registered one-hot grant
//   rd_valid   one-cycle pulse, read data for that requester is on rd_data
//   rd_data    shared read data (mem_rdata passed straight through)
//   mem_en     pixel buffer enable
//   mem_we     pixel buffer write enable
//   mem_addr   pixel buffer address
//   mem_wdata  pixel buffer write data
//   mem_rdata  pixel buffer read data, one cycle after the read
//   gnt_cnt    saturating access-cycle count (0 when the feature is off)
//
// State  | meaning
// -------+-----------------------------------------------
// S_IDLE | no grant outstanding, gnt == 0
// S_OWN  | exactly one requester holds the grant
// -----------------------------------------------------------------------------
module pix_buf_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [15:0]               gnt_cnt
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LCNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic               win_found;
    logic               owner_req;
    logic               owner_lock;
    logic               acc;
    logic [LCNT_W-1:0]  lock_cnt, lock_cnt_nxt;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // Owner index and its request/lock bits, decoded from the one-hot grant.
    always_comb begin
        owner      = '0;
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                owner      = IDX_W'(i);
                owner_req  = req[i];
                owner_lock = lock[i];
            end
        end
    end

    assign acc = |(gnt & req);

    // Memory port: driven only in an access cycle, all zeros otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && req[i]) begin
                mem_en    = 1'b1;
                mem_we    = req_we[i];
                mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search. From IDLE it starts at rr_ptr; from OWN it starts
    // just past the owner, so the owner is the last candidate considered.
    always_comb begin
        search_start = (state == S_IDLE) ? rr_ptr : wrap_inc(owner);
        win_found    = 1'b0;
        winner       = '0;
        idx          = search_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
            idx = wrap_inc(idx);
        end
        win_onehot = NUM_REQ'(1) << winner;
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_ptr_nxt   = rr_ptr;
        lock_cnt_nxt = lock_cnt;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt    = S_OWN;
                    gnt_nxt      = win_onehot;
                    rr_ptr_nxt   = wrap_inc(winner);
                    lock_cnt_nxt = '0;
                end
            end
            S_OWN: begin
                if (owner_req && owner_lock && (lock_cnt < LCNT_W'(MAX_LOCK - 1))) begin
                    lock_cnt_nxt = lock_cnt + LCNT_W'(1);
                end else begin
                    // Lock expired or released: re-arbitrate. A lone owner
                    // wins again, which restarts its lock window.
                    lock_cnt_nxt = '0;
                    if (win_found) begin
                        gnt_nxt    = win_onehot;
                        rr_ptr_nxt = wrap_inc(winner);
                    end else begin
                        state_nxt = S_IDLE;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                gnt_nxt      = '0;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
            rd_valid <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
            rd_valid <= gnt & req & ~req_we;
        end
    end

    assign rd_data = mem_rdata;

`ifdef PIX_BUF_ARB_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt <= '0;
        end else if (acc && (gnt_cnt != 16'hFFFF)) begin
            gnt_cnt <= gnt_cnt + 16'd1;
        end
    end
`else
    assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_pix_buf_arb.sv
// -----------------------------------------------------------------------------
// tb_pix_buf_arb
//   Directed bench for pix_buf_arb. Stimulus pushes the expected memory
//   accesses and read returns into queues; a negedge monitor pops and compares
//   whenever the DUT shows mem_en or rd_valid. The buffer model returns
//   addr[7:0] ^ 8'h5A one cycle after each read.
// -----------------------------------------------------------------------------
module tb_pix_buf_arb;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    typedef struct {
        logic [NR-1:0] gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
    } rd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req;
    logic [NR-1:0]    lock;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_we;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rd_valid;
    logic [DW-1:0]    rd_data;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic [15:0]      gnt_cnt;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    acc_t q_acc[$];
    rd_t  q_rd[$];
    acc_t mon_a;
    rd_t  mon_r;

    always #5 clk = ~clk;

    pix_buf_arb #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_LOCK(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_addr (req_addr),
        .req_we   (req_we),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .gnt_cnt  (gnt_cnt)
    );

    always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic exp_acc(input logic [NR-1:0] g, input logic we,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        acc_t e;
        e.gnt   = g;
        e.we    = we;
        e.addr  = ad;
        e.wdata = wd;
        q_acc.push_back(e);
    endtask

    task automatic exp_rd(input logic [NR-1:0] v, input logic [DW-1:0] d);
        rd_t e;
        e.v = v;
        e.d = d;
        q_rd.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en) begin
                if (q_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected got gnt %b addr %0h expected no access", gnt, mem_addr);
                end else begin
                    mon_a = q_acc.pop_front();
                    chk("acc_gnt",   32'(gnt),       32'(mon_a.gnt));
                    chk("acc_we",    32'(mem_we),    32'(mon_a.we));
                    chk("acc_addr",  32'(mem_addr),  32'(mon_a.addr));
                    chk("acc_wdata", 32'(mem_wdata), 32'(mon_a.wdata));
                end
            end else begin
                chk("idle_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
            end
            if (rd_valid != '0) begin
                if (q_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected got rd_valid %b expected none", rd_valid);
                end else begin
                    mon_r = q_rd.pop_front();
                    chk("rd_valid", 32'(rd_valid), 32'(mon_r.v));
                    chk("rd_data",  32'(rd_data),  32'(mon_r.d));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req       = '0;
        lock      = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        step();
        chk("rst_gnt",      32'(gnt),      32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_gnt_cnt",  32'(gnt_cnt),  32'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        checks++;
        if (q_acc.size() != 0 || q_rd.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d accesses %0d reads outstanding expected 0 0",
                     name, q_acc.size(), q_rd.size());
        end
        q_acc.delete();
        q_rd.delete();
    endtask

    initial begin
        clear_in();
        do_reset();

        // Single read by requester 0: grant one cycle later, data the cycle after.
        req_addr[0 +: AW] = 16'h0010;
        req[0]            = 1'b1;
        exp_acc(4'b0001, 1'b0, 16'h0010, 8'h00);
        exp_rd(4'b0001, 8'h4A);
        #1;
        chk("no_early_gnt", 32'(gnt), 32'd0);
        step();
        step();
        clear_in();
        drain("single_read_drain");

        // All four requesting, no lock: 0,1,2,3,0 from a freshly reset pointer.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = 16'h0100 + 16'(i);
        end
        req_wdata = {8'hC3, 8'h32, 8'hA1, 8'h10};
        req_we    = 4'b1010;
        req       = 4'b1111;
        exp_acc(4'b0001, 1'b0, 16'h0100, 8'h10);
        exp_acc(4'b0010, 1'b1, 16'h0101, 8'hA1);
        exp_acc(4'b0100, 1'b0, 16'h0102, 8'h32);
        exp_acc(4'b1000, 1'b1, 16'h0103, 8'hC3);
        exp_acc(4'b0001, 1'b0, 16'h0100, 8'h10);
        exp_rd(4'b0001, 8'h5A);
        exp_rd(4'b0100, 8'h58);
        exp_rd(4'b0001, 8'h5A);
        repeat (6) step();
        clear_in();
        drain("round_robin_drain");

        // Requester 2 locked, requester 0 waiting: 16 cycles of 2, then 0.
        do_reset();
        req_addr[2*AW +: AW]  = 16'h0200;
        req_wdata[2*DW +: DW] = 8'h22;
        req_we[2]             = 1'b1;
        req[2]                = 1'b1;
        lock[2]               = 1'b1;
        repeat (16) exp_acc(4'b0100, 1'b1, 16'h0200, 8'h22);
        exp_acc(4'b0001, 1'b0, 16'h0333, 8'h00);
        exp_rd(4'b0001, 8'h69);
        step();
        req_addr[0 +: AW] = 16'h0333;
        req[0]            = 1'b1;
        repeat (17) step();
        clear_in();
        drain("lock_limit_drain");

        // Requester 1 alone with lock for 40 cycles: no gap in the grant.
        do_reset();
        req_addr[1*AW +: AW] = 16'h0042;
        req[1]               = 1'b1;
        lock[1]              = 1'b1;
        repeat (40) exp_acc(4'b0010, 1'b0, 16'h0042, 8'h00);
        repeat (40) exp_rd(4'b0010, 8'h18);
        repeat (41) step();
        clear_in();
        drain("lone_lock_drain");

        // Reset in the middle of a read by requester 3.
        do_reset();
        req_addr[3*AW +: AW] = 16'h0077;
        req[3]               = 1'b1;
        exp_acc(4'b1000, 1'b0, 16'h0077, 8'h00);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_in();
        chk("midrst_gnt",      32'(gnt),      32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        drain("midrst_drain");

`ifdef PIX_BUF_ARB_GNT_CNT_EN
        do_reset();
        mon_en    = 1'b0;
        req_we[0] = 1'b1;
        req[0]    = 1'b1;
        repeat (70001) step();
        chk("gnt_cnt_sat", 32'(gnt_cnt), 32'h0000FFFF);
        clear_in();
        repeat (3) step();
        mon_en = 1'b1;
`else
        chk("gnt_cnt_tied", 32'(gnt_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
